// File: rtl/univ_shift_reg_p_pkg.sv
// Shared encodings for the parametrised universal shift register.
// The manual operation codes and the burst FSM states live here so that the
// next-value mux, the top level and any surrounding logic agree on them.
package univ_shift_pkg;

    // Manual operation select carried on i_mode
    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHR  = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_LOAD = 3'b011,
        MODE_ROR  = 3'b100,
        MODE_ROL  = 3'b101,
        MODE_ASR  = 3'b110,
        MODE_RSV  = 3'b111
    } mode_e;

    // Burst serialiser states
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

endpackage

// File: rtl/univ_shift_reg_p_shift_next_val.sv
// Combinational next-value mux for the universal shift register.
// Given the current word, an operation code and the serial inputs it returns
// the word the register should hold after the next update. The burst path
// reuses it by forcing a logical right shift with a zero serial input.
module shift_next_val
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur_q,
    input  logic [2:0]       mode,
    input  logic             sr_in,
    input  logic             sl_in,
    input  logic [WIDTH-1:0] load_d,
    output logic [WIDTH-1:0] next_q
);

    // Select the next word; hold and the reserved code both keep the current value
    always_comb begin
        next_q = cur_q;
        case (mode)
            MODE_SHR:  next_q = {sr_in, cur_q[WIDTH-1:1]};
            MODE_SHL:  next_q = {cur_q[WIDTH-2:0], sl_in};
            MODE_LOAD: next_q = load_d;
            MODE_ROR:  next_q = {cur_q[0], cur_q[WIDTH-1:1]};
            MODE_ROL:  next_q = {cur_q[WIDTH-2:0], cur_q[WIDTH-1]};
            MODE_ASR:  next_q = {cur_q[WIDTH-1], cur_q[WIDTH-1:1]};
            default:   next_q = cur_q;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg_p.sv
// Parametrised universal shift register with an autonomous burst serialiser.
// In IDLE the register follows the manual operation on i_mode. An i_start in
// IDLE loads i_d and then shifts it out LSB-first on o_so_r over WIDTH
// enabled cycles, with o_busy covering the burst and a one-cycle o_done after
// the last shift. i_en gates every register, so a disabled clock freezes the
// burst mid-stream and stretches a pending o_done.
module univ_shift_reg_p
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [2:0]       i_mode,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_sr_in,
    input  logic             i_sl_in,
    input  logic             i_start,
    output logic [WIDTH-1:0] o_q,
    output logic             o_so_r,
    output logic             o_so_l,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_cnt
);

    // Count value seen on the edge that performs the final burst shift
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_d;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_d;
    logic             done_r;
    logic             done_d;

    logic [2:0]       nv_mode;
    logic             nv_sr_in;
    logic [WIDTH-1:0] shifted_q;

    // During a burst the shared mux is steered to a zero-fill right shift
    always_comb begin
        nv_mode  = i_mode;
        nv_sr_in = i_sr_in;
        if (state_q == ST_BURST) begin
            nv_mode  = MODE_SHR;
            nv_sr_in = 1'b0;
        end
    end

    shift_next_val #(
        .WIDTH (WIDTH)
    ) u_next_val (
        .cur_q  (q_r),
        .mode   (nv_mode),
        .sr_in  (nv_sr_in),
        .sl_in  (i_sl_in),
        .load_d (i_d),
        .next_q (shifted_q)
    );

    // Next-state logic for the burst FSM, register word, shift counter and done pulse
    always_comb begin
        state_d = state_q;
        q_d     = q_r;
        cnt_d   = cnt_r;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    q_d     = i_d;
                    cnt_d   = '0;
                    state_d = ST_BURST;
                end else begin
                    q_d = shifted_q;
                end
            end
            ST_BURST: begin
                q_d   = shifted_q;
                cnt_d = cnt_r + CNT_W'(1);
                if (cnt_r == LAST_CNT) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; everything holds while i_en is low
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            q_r     <= '0;
            cnt_r   <= '0;
            done_r  <= 1'b0;
        end else if (i_en) begin
            state_q <= state_d;
            q_r     <= q_d;
            cnt_r   <= cnt_d;
            done_r  <= done_d;
        end
    end

    assign o_q    = q_r;
    assign o_so_r = q_r[0];
    assign o_so_l = q_r[WIDTH-1];
    assign o_busy = (state_q == ST_BURST);
    assign o_done = done_r;
    assign o_cnt  = cnt_r;

endmodule

// File: tb/tb_univ_shift_reg_p.sv
// Bench for univ_shift_reg_p with an 8-bit and a 16-bit instance.
// Stimulus pushes hand-computed expected register states and serial bits into
// queues; independent monitors pop and compare them against the outputs.
module tb_univ_shift_reg_p;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    logic       en8, sr8, sl8, start8;
    logic [2:0] mode8;
    logic [7:0] d8;
    logic [7:0] q8;
    logic       sor8, sol8, busy8, done8;
    logic [3:0] cnt8;

    logic        en16, sr16, sl16, start16;
    logic [2:0]  mode16;
    logic [15:0] d16;
    logic [15:0] q16;
    logic        sor16, sol16, busy16, done16;
    logic [4:0]  cnt16;

    univ_shift_reg_p #(.WIDTH(8)) dut8 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (en8),
        .i_mode  (mode8),
        .i_d     (d8),
        .i_sr_in (sr8),
        .i_sl_in (sl8),
        .i_start (start8),
        .o_q     (q8),
        .o_so_r  (sor8),
        .o_so_l  (sol8),
        .o_busy  (busy8),
        .o_done  (done8),
        .o_cnt   (cnt8)
    );

    univ_shift_reg_p #(.WIDTH(16)) dut16 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (en16),
        .i_mode  (mode16),
        .i_d     (d16),
        .i_sr_in (sr16),
        .i_sl_in (sl16),
        .i_start (start16),
        .o_q     (q16),
        .o_so_r  (sor16),
        .o_so_l  (sol16),
        .o_busy  (busy16),
        .o_done  (done16),
        .o_cnt   (cnt16)
    );

    typedef struct {
        int          sel;
        string       name;
        logic [63:0] q;
        logic        busy;
        logic        done;
        int          cnt;
    } exp_t;

    exp_t exp_q[$];
    logic stream8_q[$];
    logic stream16_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input int sel, input string name, input logic [63:0] q,
                            input logic busy, input logic done, input int cnt);
        exp_t e;
        e.sel  = sel;
        e.name = name;
        e.q    = q;
        e.busy = busy;
        e.done = done;
        e.cnt  = cnt;
        exp_q.push_back(e);
    endtask

    task automatic push_burst(input int sel, input logic [63:0] word, input int width);
        for (int i = 0; i < width; i++) begin
            if (sel == 0) stream8_q.push_back(word[i]);
            else          stream16_q.push_back(word[i]);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic en, input logic [2:0] mode,
                                 input logic [63:0] d, input logic sr, input logic sl,
                                 input logic start, input string name,
                                 input logic [63:0] eq, input logic eb, input logic ed,
                                 input int ec);
        if (sel == 0) begin
            en8 = en; mode8 = mode; d8 = d[7:0]; sr8 = sr; sl8 = sl; start8 = start;
            en16 = 1'b0; start16 = 1'b0;
        end else begin
            en16 = en; mode16 = mode; d16 = d[15:0]; sr16 = sr; sl16 = sl; start16 = start;
            en8 = 1'b0; start8 = 1'b0;
        end
        @(posedge clk);
        #1;
        push_exp(sel, name, eq, eb, ed, ec);
    endtask

    // Register-state monitor: compares every queued expectation once outputs settle
    initial begin
        exp_t        e;
        logic [63:0] aq;
        logic        ab, ad, asr, asl;
        int          ac, w;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.sel == 0) begin
                    aq = {56'b0, q8}; ab = busy8; ad = done8; ac = int'(cnt8);
                    asr = sor8; asl = sol8; w = 8;
                end else begin
                    aq = {48'b0, q16}; ab = busy16; ad = done16; ac = int'(cnt16);
                    asr = sor16; asl = sol16; w = 16;
                end
                checkOutput({e.name, ".q"},    aq, e.q);
                checkOutput({e.name, ".busy"}, 64'(ab), 64'(e.busy));
                checkOutput({e.name, ".done"}, 64'(ad), 64'(e.done));
                checkOutput({e.name, ".cnt"},  64'(ac), 64'(e.cnt));
                checkOutput({e.name, ".so_r"}, 64'(asr), 64'(e.q[0]));
                checkOutput({e.name, ".so_l"}, 64'(asl), 64'(e.q[w-1]));
            end
        end
    end

    // Serial consumer for the 8-bit instance: takes o_so_r on each enabled busy cycle
    initial begin
        logic sb;
        forever begin
            @(negedge clk);
            #1;
            if (busy8 === 1'b1 && en8 === 1'b1) begin
                compared++;
                if (stream8_q.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL stream8: got bit %0b, required no bit (not busy)", sor8);
                end else begin
                    sb = stream8_q.pop_front();
                    if (sor8 !== sb) begin
                        mismatched++;
                        $display("[TB] FAIL stream8: got %0b, required %0b", sor8, sb);
                    end
                end
            end
        end
    end

    // Serial consumer for the 16-bit instance
    initial begin
        logic sb;
        forever begin
            @(negedge clk);
            #1;
            if (busy16 === 1'b1 && en16 === 1'b1) begin
                compared++;
                if (stream16_q.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL stream16: got bit %0b, required no bit (not busy)", sor16);
                end else begin
                    sb = stream16_q.pop_front();
                    if (sor16 !== sb) begin
                        mismatched++;
                        $display("[TB] FAIL stream16: got %0b, required %0b", sor16, sb);
                    end
                end
            end
        end
    end

    // Directed stimulus sequence
    initial begin
        en8 = 1'b0; mode8 = 3'b000; d8 = '0; sr8 = 1'b0; sl8 = 1'b0; start8 = 1'b0;
        en16 = 1'b0; mode16 = 3'b000; d16 = '0; sr16 = 1'b0; sl16 = 1'b0; start16 = 1'b0;
        #1;
        push_exp(0, "reset8", 64'h0, 1'b0, 1'b0, 0);
        push_exp(1, "reset16", 64'h0, 1'b0, 1'b0, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        $display("[TB] manual modes");

        applyStimulus(0, 1, 3'b011, 64'hF1, 0, 0, 0, "load_f1",  64'hF1, 0, 0, 0);
        applyStimulus(0, 1, 3'b001, 64'h00, 0, 0, 0, "shr",      64'h78, 0, 0, 0);
        applyStimulus(0, 1, 3'b011, 64'hF1, 0, 0, 0, "load_f1b", 64'hF1, 0, 0, 0);
        applyStimulus(0, 1, 3'b010, 64'h00, 0, 1, 0, "shl",      64'hE3, 0, 0, 0);
        applyStimulus(0, 1, 3'b000, 64'h55, 1, 1, 0, "hold",     64'hE3, 0, 0, 0);
        applyStimulus(0, 1, 3'b111, 64'h55, 1, 1, 0, "reserved", 64'hE3, 0, 0, 0);
        applyStimulus(0, 1, 3'b011, 64'h82, 0, 0, 0, "load_82",  64'h82, 0, 0, 0);
        applyStimulus(0, 1, 3'b100, 64'h00, 0, 0, 0, "ror",      64'h41, 0, 0, 0);
        applyStimulus(0, 1, 3'b110, 64'h00, 1, 1, 0, "asr_pos",  64'h20, 0, 0, 0);
        applyStimulus(0, 1, 3'b011, 64'h82, 0, 0, 0, "load_82b", 64'h82, 0, 0, 0);
        applyStimulus(0, 1, 3'b101, 64'h00, 0, 0, 0, "rol",      64'h05, 0, 0, 0);
        applyStimulus(0, 1, 3'b011, 64'h82, 0, 0, 0, "load_82c", 64'h82, 0, 0, 0);
        applyStimulus(0, 1, 3'b110, 64'h00, 0, 0, 0, "asr_neg",  64'hC1, 0, 0, 0);
        applyStimulus(0, 1, 3'b001, 64'h00, 1, 0, 0, "shr_one",  64'hE0, 0, 0, 0);
        applyStimulus(0, 0, 3'b011, 64'h33, 0, 0, 0, "en_low",   64'hE0, 0, 0, 0);

        $display("[TB] asynchronous reset between edges");
        applyStimulus(0, 1, 3'b011, 64'hF1, 0, 0, 0, "load_pre_rst", 64'hF1, 0, 0, 0);
        @(negedge clk);
        #2;
        push_exp(0, "async_clr", 64'h0, 1'b0, 1'b0, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] burst 0xA5");
        applyStimulus(0, 1, 3'b011, 64'hA5, 0, 0, 1, "b1_start", 64'hA5, 1, 0, 0);
        push_burst(0, 64'hA5, 8);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(0, 1, (k == 3) ? 3'b011 : 3'b010, (k == 3) ? 64'h3C : 64'hFF, 1, 1, (k == 3),
                          $sformatf("b1_shift%0d", k), 64'hA5 >> k, (k < 8), (k == 8), k);
        end
        applyStimulus(0, 1, 3'b011, 64'h3C, 0, 0, 0, "b1_manual_cnt", 64'h3C, 0, 0, 8);

        $display("[TB] burst with clock-enable gaps");
        applyStimulus(0, 1, 3'b000, 64'hA5, 0, 0, 1, "b2_start", 64'hA5, 1, 0, 0);
        push_burst(0, 64'hA5, 8);
        for (int k = 1; k <= 2; k++) begin
            applyStimulus(0, 1, 3'b000, 64'h00, 0, 0, 0, $sformatf("b2_shift%0d", k),
                          64'hA5 >> k, 1, 0, k);
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 3'b011, 64'hFF, 1, 1, 1, $sformatf("b2_frozen%0d", k),
                          64'h29, 1, 0, 2);
        end
        for (int k = 3; k <= 8; k++) begin
            applyStimulus(0, 1, 3'b000, 64'h00, 0, 0, 0, $sformatf("b2_shift%0d", k),
                          64'hA5 >> k, (k < 8), (k == 8), k);
        end
        applyStimulus(0, 0, 3'b000, 64'h00, 0, 0, 1, "b2_done_stretch", 64'h00, 0, 1, 8);
        applyStimulus(0, 1, 3'b000, 64'h5A, 0, 0, 1, "b3_back_to_back", 64'h5A, 1, 0, 0);
        push_burst(0, 64'h5A, 8);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(0, 1, 3'b000, 64'h00, 0, 0, 0, $sformatf("b3_shift%0d", k),
                          64'h5A >> k, 1, 0, k);
        end

        $display("[TB] reset mid-burst");
        @(negedge clk);
        #2;
        stream8_q.delete();
        push_exp(0, "abort_clr", 64'h0, 1'b0, 1'b0, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(0, 1, 3'b000, 64'h00, 0, 0, 0, "post_abort", 64'h0, 0, 0, 0);

        $display("[TB] 16-bit burst 0xBEEF");
        applyStimulus(1, 1, 3'b000, 64'hBEEF, 0, 0, 1, "w16_start", 64'hBEEF, 1, 0, 0);
        push_burst(1, 64'hBEEF, 16);
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1, 1, 3'b000, 64'h00, 0, 0, 0, $sformatf("w16_shift%0d", k),
                          64'hBEEF >> k, (k < 16), (k == 16), k);
        end
        applyStimulus(1, 1, 3'b000, 64'h00, 0, 0, 0, "w16_idle", 64'h0, 0, 0, 16);

        @(negedge clk);
        #3;
        checkOutput("stream8_leftover",  64'(stream8_q.size()),  64'h0);
        checkOutput("stream16_leftover", 64'(stream16_q.size()), 64'h0);
        checkOutput("scoreboard_leftover", 64'(exp_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
